// File: rtl/ikaopll_bus_sequencer_if.sv
// ikaopll_bus_sequencer_if: host write-request channel plus the YM2413 CPU bus pins
// master: host side (drives requests, observes the bus); slave: the sequencer
interface ikaopll_bus_sequencer_if;
   logic       wr_valid, wr_ready, cs_n, wr_n, a0;
   logic [7:0] wr_addr, wr_data, d;
   modport master (output wr_valid, wr_addr, wr_data, input wr_ready, cs_n, wr_n, a0, d);
   modport slave (input wr_valid, wr_addr, wr_data, output wr_ready, cs_n, wr_n, a0, d);
endinterface

// File: rtl/ikaopll_bus_sequencer.sv
// ikaopll_bus_sequencer: FIFO-buffered register writes replayed as YM2413-legal CPU bus cycles
// Ports: clk/rst (rst asynchronous, active-high); phim_pcen_n is the active-low phiM
//   enable that paces all bus timing; flush clears the FIFO; bus (slave modport) holds
//   the valid/ready request channel and the CS_n/WR_n/A0/D pins; busy flags a
//   transaction in flight; fifo_level is the number of queued requests.
// Option: define IKAOPLL_SEQ_ADDR_CACHE_EN to skip the address phase when the address
//   matches the one last latched into the core.
module ikaopll_bus_sequencer #(
   parameter int FIFO_DEPTH_LOG2  = 3,
   parameter int STROBE_CYCLES    = 2,
   parameter int ADDR_WAIT_CYCLES = 12,
   parameter int DATA_WAIT_CYCLES = 84
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     phim_pcen_n,
   input  logic                     flush,
   ikaopll_bus_sequencer_if.slave   bus,
   output logic                     busy,
   output logic [FIFO_DEPTH_LOG2:0] fifo_level
);
   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int PW = FIFO_DEPTH_LOG2;
   localparam int LW = FIFO_DEPTH_LOG2 + 1;
   localparam int M1 = STROBE_CYCLES > ADDR_WAIT_CYCLES ? STROBE_CYCLES : ADDR_WAIT_CYCLES;
   localparam int MAXC = M1 > DATA_WAIT_CYCLES ? M1 : DATA_WAIT_CYCLES;
   localparam int CW = $clog2(MAXC) + 1;
   typedef enum logic [2:0] {IDLE, ASTB, AWAIT, DSTB, DWAIT} state_t;
   state_t        state;
   logic [CW-1:0] cnt;
   logic [15:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level_nxt;
   logic [7:0]    data_q, head_addr, head_data;
   logic          strb_n, en, done, push, start, hit;
   assign en = !phim_pcen_n;
   assign {head_addr, head_data} = mem[rd_ptr];
   // CS_n and WR_n come from one flop so they can never skew apart
   assign bus.cs_n = strb_n;
   assign bus.wr_n = strb_n;
   always_comb begin
      done = (state == ASTB || state == DSTB) ? cnt == CW'(STROBE_CYCLES - 1) :
             state == AWAIT ? cnt == CW'(ADDR_WAIT_CYCLES - 1) : cnt == CW'(DATA_WAIT_CYCLES - 1);
      push = bus.wr_valid & bus.wr_ready & !flush;
      // a pop happens from IDLE or on the final DWAIT enable (back-to-back); flush blocks it
      start = en & !flush & (fifo_level != '0) & (state == IDLE | (state == DWAIT & done));
      level_nxt = flush ? '0 : fifo_level + LW'(push) - LW'(start);
   end
`ifdef IKAOPLL_SEQ_ADDR_CACHE_EN
   logic       cache_valid;
   logic [7:0] cache_addr;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cache_valid <= 1'b0;
         cache_addr  <= '0;
      end else if (start && !hit) begin
         cache_valid <= 1'b1;
         cache_addr  <= head_addr;
      end
   end
   assign hit = cache_valid && cache_addr == head_addr;
`else
   assign hit = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {bus.wr_addr, bus.wr_data};
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_level   <= '0;
         bus.wr_ready <= 1'b1;
         state        <= IDLE;
         cnt          <= '0;
         strb_n       <= 1'b1;
         bus.a0       <= 1'b0;
         bus.d        <= '0;
         data_q       <= '0;
         busy         <= 1'b0;
      end else begin
         fifo_level   <= level_nxt;
         bus.wr_ready <= level_nxt < LW'(DEPTH);
         wr_ptr       <= wr_ptr + PW'(push);
         rd_ptr       <= flush ? wr_ptr : rd_ptr + PW'(start);
         if (start) begin
            state  <= hit ? DSTB : ASTB;
            cnt    <= '0;
            strb_n <= 1'b0;
            bus.a0 <= hit;
            bus.d  <= hit ? head_data : head_addr;
            data_q <= head_data;
            busy   <= 1'b1;
         end else if (en && state != IDLE) begin
            cnt <= done ? '0 : cnt + CW'(1);
            if (done) begin
               state  <= state == ASTB ? AWAIT : state == AWAIT ? DSTB : state == DSTB ? DWAIT : IDLE;
               strb_n <= state != AWAIT;
               busy   <= state != DWAIT;
               if (state == AWAIT) begin
                  bus.a0 <= 1'b1;
                  bus.d  <= data_q;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_ikaopll_bus_sequencer.sv
// tb_ikaopll_bus_sequencer: directed and randomized checks of the bus sequencer against an event-timeline model
module tb_ikaopll_bus_sequencer;
   localparam int S = 2, AW = 12, DW = 84, FULL = 2 * S + AW + DW;
`ifdef IKAOPLL_SEQ_ADDR_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif
   typedef struct { int t; logic [9:0] v; } ev_t;
   logic        clk = 1'b0, rst = 1'b1, pcen_n = 1'b1, flush = 1'b0, busy;
   logic [3:0]  level;
   int          passed = 0, total = 0, en_idx = 0, mode = 1, ph = 0, exp_end = 0, e0 = 0;
   ev_t         obs_q[$], exp_q[$];
   int          busy_fall[$];
   logic [15:0] reqs[$];
   logic        m_valid = 1'b0;
   logic [7:0]  m_last = '0;
   ikaopll_bus_sequencer_if bus ();
   ikaopll_bus_sequencer dut (.clk(clk), .rst(rst), .phim_pcen_n(pcen_n), .flush(flush),
                              .bus(bus), .busy(busy), .fifo_level(level));
   initial forever #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
      total++;
      assert (obs_v === exp_v) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs_v, exp_v);
   endtask
   // enable pattern: 0 = every 4th clock, 1 = stalled, 2 = random
   initial forever begin
      @(negedge clk);
      ph++;
      pcen_n = mode == 0 ? (ph % 4 != 0) : mode == 1 ? 1'b1 : 1'($urandom_range(0, 1));
   end
   // monitor: counts enables, logs every strobe edge as {low, A0, D} and busy falls
   initial begin
      logic       was_en, prev_busy;
      logic [9:0] prev;
      prev = 10'h200;
      prev_busy = 1'b0;
      forever begin
         @(posedge clk);
         was_en = !pcen_n;
         #1;
         if (was_en) en_idx++;
         if (!rst) begin
            if (!was_en) chk("hold_off_enable", {bus.cs_n, bus.a0, bus.d}, prev);
            if (bus.cs_n !== prev[9]) begin
               chk("cs_wr_together", bus.wr_n, bus.cs_n);
               obs_q.push_back('{en_idx, {!bus.cs_n, bus.a0, bus.d}});
            end
            if (prev_busy && !busy) busy_fall.push_back(en_idx);
         end
         prev = {bus.cs_n, bus.a0, bus.d};
         prev_busy = busy;
      end
   end
   task automatic wait_en(input int target);
      int n = 0;
      while (en_idx < target && n < 20000) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (en_idx < target) chk("enable_timeout", en_idx, target);
   endtask
   task automatic push(input logic [7:0] a, input logic [7:0] dv);
      int   n = 0;
      logic acc;
      do begin
         @(negedge clk);
         bus.wr_valid = 1'b1;
         bus.wr_addr = a;
         bus.wr_data = dv;
         acc = bus.wr_ready;
         @(posedge clk);
         #2;
         n++;
      end while (!acc && n < 5000);
      bus.wr_valid = 1'b0;
      if (!acc) chk("push_timeout", acc, 1'b1);
      reqs.push_back({a, dv});
   endtask
   // expected strobe timeline from the popped requests, first address strobe at enable start_en
   task automatic model(input int start_en);
      int         t;
      logic [7:0] a, dv;
      t = start_en;
      foreach (reqs[i]) begin
         a = reqs[i][15:8];
         dv = reqs[i][7:0];
         if (CACHE && m_valid && a == m_last) begin
            exp_q.push_back('{t, {2'b11, dv}});
            exp_q.push_back('{t + S, {2'b01, dv}});
            t += S + DW;
         end else begin
            exp_q.push_back('{t, {2'b10, a}});
            exp_q.push_back('{t + S, {2'b00, a}});
            exp_q.push_back('{t + S + AW, {2'b11, dv}});
            exp_q.push_back('{t + 2 * S + AW, {2'b01, dv}});
            t += FULL;
            m_valid = 1'b1;
            m_last = a;
         end
      end
      exp_end = t;
      reqs.delete();
   endtask
   task automatic compare(input string tag);
      ev_t o, e;
      wait_en(exp_end + 20);
      chk({tag, "_events"}, obs_q.size(), exp_q.size());
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         chk({tag, "_time"}, o.t, e.t);
         chk({tag, "_bus"}, o.v, e.v);
      end
      chk({tag, "_busy_drops"}, busy_fall.size(), 1);
      if (busy_fall.size() > 0) chk({tag, "_busy_time"}, busy_fall[0], exp_end);
      obs_q.delete();
      exp_q.delete();
      busy_fall.delete();
   endtask
   initial begin
      int n;
      logic [7:0] a9, d9;
      bus.wr_valid = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_cs_n", bus.cs_n, 1'b1);
      chk("rst_wr_n", bus.wr_n, 1'b1);
      chk("rst_a0", bus.a0, 1'b0);
      chk("rst_d", bus.d, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_level", level, 4'd0);
      chk("rst_ready", bus.wr_ready, 1'b1);
      rst = 1'b0;
      mode = 0;
      // single write
      push(8'h10, 8'h55);
      e0 = en_idx + 1;
      model(e0);
      compare("single");
      // three queued writes, strobes 100 enables apart
      mode = 1;
      push(8'h01, 8'hA1);
      push(8'h02, 8'hA2);
      push(8'h03, 8'hA3);
      chk("three_level", level, 4'd3);
      mode = 0;
      e0 = en_idx + 1;
      wait_en(e0);
      chk("pop1_level", level, 4'd2);
      wait_en(e0 + FULL);
      chk("pop2_level", level, 4'd1);
      wait_en(e0 + 2 * FULL);
      chk("pop3_level", level, 4'd0);
      model(e0);
      compare("three");
      // fill to full with enables stalled, ninth request waits for the first pop
      mode = 1;
      for (int i = 0; i < 8; i++) push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      a9 = 8'($urandom_range(0, 255));
      d9 = 8'($urandom_range(0, 255));
      @(negedge clk);
      bus.wr_valid = 1'b1;
      bus.wr_addr = a9;
      bus.wr_data = d9;
      chk("full_ready", bus.wr_ready, 1'b0);
      @(posedge clk);
      #2;
      chk("full_level", level, 4'd8);
      mode = 0;
      e0 = en_idx + 1;
      push(a9, d9);
      chk("ninth_after_pop", obs_q.size(), 1);
      chk("ninth_level", level, 4'd8);
      model(e0);
      compare("full");
      // flush during AWAIT: in-flight write completes, nothing else follows
      mode = 1;
      for (int i = 0; i < 6; i++) push(8'h50 + 8'(i), 8'hC0 + 8'(i));
      mode = 0;
      e0 = en_idx + 1;
      wait_en(e0 + S + 2);
      chk("await_level", level, 4'd5);
      chk("await_cs_n", bus.cs_n, 1'b1);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #2;
      flush = 1'b0;
      chk("flush_level", level, 4'd0);
      chk("flush_ready", bus.wr_ready, 1'b1);
      while (reqs.size() > 1) void'(reqs.pop_back());
      model(e0);
      compare("flush");
      chk("flush_end_level", level, 4'd0);
      // asynchronous reset during the data strobe
      mode = 1;
      for (int i = 0; i < 3; i++) push(8'h60 + 8'(i), 8'hD0 + 8'(i));
      mode = 0;
      e0 = en_idx + 1;
      wait_en(e0 + S + AW + 1);
      chk("dstb_cs_n", bus.cs_n, 1'b0);
      chk("dstb_a0", bus.a0, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("arst_cs_n", bus.cs_n, 1'b1);
      chk("arst_wr_n", bus.wr_n, 1'b1);
      chk("arst_level", level, 4'd0);
      chk("arst_ready", bus.wr_ready, 1'b1);
      chk("arst_busy", busy, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_valid = 1'b0;
      reqs.delete();
      obs_q.delete();
      exp_q.delete();
      busy_fall.delete();
      push(8'h7E, 8'h3C);
      e0 = en_idx + 1;
      model(e0);
      compare("post_reset");
      // repeated address (address-phase skip when the cache is built)
      push(8'h20, 8'h11);
      e0 = en_idx + 1;
      push(8'h20, 8'h22);
      push(8'h30, 8'h33);
      model(e0);
      compare("repeat_addr");
      // random enables and data over a small address set
      mode = 2;
      n = $urandom_range(4, 6);
      push(8'h40 + 8'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      e0 = en_idx + 1;
      for (int i = 1; i < n; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         push(8'h40 + 8'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      end
      model(e0);
      compare("random");
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
